// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, port ids and the latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int unsigned CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational request picker for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin tie breaking; otherwise the data port wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic d_req,
    input  logic i_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_valid = d_req | i_req;
        grant_id    = PORT_I;
        if (d_req && i_req) begin
            // on a tie, the port that did not win last time goes first
            grant_id = ~last_grant;
        end else if (d_req) begin
            grant_id = PORT_D;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = d_req | i_req;
        grant_id    = d_req ? PORT_D : PORT_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported 16-bit memory between the fetch and data ports with a programmable
// access latency. Tie breaking is round-robin when MEM_ARB_RR_EN is defined, data-first otherwise.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [15:0]           d_rdata,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic                  i_err,
    output logic [15:0]           i_rdata,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    localparam cnt_t CNT_LOAD = (LATENCY > 1) ? cnt_t'(LATENCY - 2) : '0;

    state_t                state;
    cnt_t                  cnt;
    logic                  last_grant;
    logic                  port_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wdata_q;

    logic                  grant_valid;
    logic                  grant_id;
    logic                  g_wr;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [15:0]           g_wdata;

    mem_arb_pick u_pick (
        .d_req       (d_req),
        .i_req       (i_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Request fields of the winning port; fetch is always a read.
    always_comb begin
        g_wr    = (grant_id == PORT_D) && d_wr;
        g_addr  = (grant_id == PORT_D) ? d_addr : i_addr;
        g_wdata = (grant_id == PORT_D) ? d_wdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= PORT_I;
            port_q      <= PORT_D;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            d_ack       <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= '0;
            i_ack       <= 1'b0;
            i_err       <= 1'b0;
            i_rdata     <= '0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        port_q     <= grant_id;
                        wr_q       <= g_wr;
                        addr_q     <= g_addr;
                        wdata_q    <= g_wdata;
                        cnt        <= CNT_LOAD;
                        last_grant <= grant_id;
                        if (g_addr[0]) begin
                            // misaligned: answer with an error, never touch memory
                            state <= RESP;
                            d_ack <= (grant_id == PORT_D);
                            d_err <= (grant_id == PORT_D);
                            i_ack <= (grant_id == PORT_I);
                            i_err <= (grant_id == PORT_I);
                        end else if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state       <= ACCESS;
                            mem_enable  <= 1'b1;
                            mem_wr      <= g_wr;
                            mem_addr    <= g_addr;
                            mem_data_in <= g_wdata;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state       <= ACCESS;
                        mem_enable  <= 1'b1;
                        mem_wr      <= wr_q;
                        mem_addr    <= addr_q;
                        mem_data_in <= wdata_q;
                    end else begin
                        cnt <= cnt - cnt_t'(1);
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    mem_enable  <= 1'b0;
                    mem_wr      <= 1'b0;
                    mem_addr    <= '0;
                    mem_data_in <= '0;
                    d_ack       <= (port_q == PORT_D);
                    i_ack       <= (port_q == PORT_I);
                    d_rdata     <= ((port_q == PORT_D) && !wr_q) ? mem_data_out : '0;
                    i_rdata     <= ((port_q == PORT_I) && !wr_q) ? mem_data_out : '0;
                end
                RESP: begin
                    state   <= IDLE;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    d_rdata <= '0;
                    i_ack   <= 1'b0;
                    i_err   <= 1'b0;
                    i_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LATENCY=2 instance plus a LATENCY=1 instance).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        d_req, d_wr, i_req;
    logic [15:0] d_addr, d_wdata, i_addr;
    logic        d_ack, d_err, i_ack, i_err;
    logic [15:0] d_rdata, i_rdata;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;

    logic        d_req1, d_wr1, i_req1;
    logic [15:0] d_addr1, d_wdata1, i_addr1;
    logic        d_ack1, d_err1, i_ack1, i_err1;
    logic [15:0] d_rdata1, i_rdata1;
    logic        mem_enable1, mem_wr1;
    logic [15:0] mem_addr1, mem_data_in1, mem_data_out1;

    logic [15:0] mem [0:32767];
    logic        bd_we;
    logic [14:0] bd_idx;
    logic [15:0] bd_dat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge, plus a backdoor preload.
    assign mem_data_out  = mem[mem_addr[15:1]];
    assign mem_data_out1 = mem[mem_addr1[15:1]];
    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_dat;
        else if (mem_enable && mem_wr)
            mem[mem_addr[15:1]] <= mem_data_in;
    end

    mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr),
        .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.ADDR_WIDTH(16), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_err(d_err1), .d_rdata(d_rdata1),
        .i_req(i_req1), .i_addr(i_addr1),
        .i_ack(i_ack1), .i_err(i_err1), .i_rdata(i_rdata1),
        .mem_enable(mem_enable1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
    );

    task automatic preload(input logic [14:0] idx, input logic [15:0] dat);
        bd_we  = 1'b1;
        bd_idx = idx;
        bd_dat = dat;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        d_req = 1'b0; i_req = 1'b0; d_req1 = 1'b0; i_req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({d_ack, d_err, d_rdata, i_ack, i_err, i_rdata, mem_enable, mem_wr, mem_addr, mem_data_in} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got d_ack=%b d_err=%b d_rdata=%h i_ack=%b i_err=%b i_rdata=%h en=%b wr=%b addr=%h din=%h, expected all 0",
                     d_ack, d_err, d_rdata, i_ack, i_err, i_rdata, mem_enable, mem_wr, mem_addr, mem_data_in);
        end
        n_checks++;
        if ({d_ack1, d_err1, d_rdata1, i_ack1, i_err1, i_rdata1, mem_enable1, mem_wr1, mem_addr1, mem_data_in1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_lat1: got ack=%b/%b en=%b addr=%h, expected all 0",
                     d_ack1, i_ack1, mem_enable1, mem_addr1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_data_read();
        preload(15'h0008, 16'hBEEF);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010; d_wdata = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_enable, d_ack, i_ack} !== {c == 2, c == 3, 1'b0}) begin
                n_fail++;
                $display("FAIL read_timing c=%0d: got en/d_ack/i_ack=%b%b%b expected %b%b0",
                         c, mem_enable, d_ack, i_ack, c == 2, c == 3);
            end
            if (c == 2) begin
                n_checks++;
                if ({mem_wr, mem_addr} !== {1'b0, 16'h0010}) begin
                    n_fail++;
                    $display("FAIL read_mem_bus: got wr=%b addr=%h expected wr=0 addr=0010", mem_wr, mem_addr);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({d_err, d_rdata} !== {1'b0, 16'hBEEF}) begin
                    n_fail++;
                    $display("FAIL read_data: got err=%b rdata=%h expected err=0 rdata=beef", d_err, d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_req = 1'b0;
        end
    endtask

    task automatic test_write_fetch();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_enable, mem_wr, d_ack} !== {c == 2, c == 2, c == 3}) begin
                n_fail++;
                $display("FAIL write_timing c=%0d: got en/wr/ack=%b%b%b expected %b%b%b",
                         c, mem_enable, mem_wr, d_ack, c == 2, c == 2, c == 3);
            end
            if (c == 2) begin
                n_checks++;
                if ({mem_addr, mem_data_in} !== {16'h0020, 16'h1234}) begin
                    n_fail++;
                    $display("FAIL write_mem_bus: got addr=%h din=%h expected 0020 1234", mem_addr, mem_data_in);
                end
            end
            if (c == 3) begin
                n_checks++;
                if ({d_err, d_rdata} !== 17'h0) begin
                    n_fail++;
                    $display("FAIL write_resp: got err=%b rdata=%h expected 0 0000", d_err, d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_req = 1'b0;
        end
        d_wr = 1'b0;
        i_req = 1'b1; i_addr = 16'h0020;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_enable, mem_wr, i_ack, d_ack} !== {c == 2, 1'b0, c == 3, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_timing c=%0d: got en/wr/i_ack/d_ack=%b%b%b%b expected %b0%b0",
                         c, mem_enable, mem_wr, i_ack, d_ack, c == 2, c == 3);
            end
            if (c == 3) begin
                n_checks++;
                if ({i_err, i_rdata} !== {1'b0, 16'h1234}) begin
                    n_fail++;
                    $display("FAIL fetch_data: got err=%b rdata=%h expected err=0 rdata=1234", i_err, i_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 3) i_req = 1'b0;
        end
    endtask

    task automatic test_misaligned();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0021;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_enable, d_ack, d_err} !== {1'b0, c == 1, c == 1}) begin
                n_fail++;
                $display("FAIL misaligned_timing c=%0d: got en/ack/err=%b%b%b expected 0%b%b",
                         c, mem_enable, d_ack, d_err, c == 1, c == 1);
            end
            if (c == 1) begin
                n_checks++;
                if (d_rdata !== 16'h0) begin
                    n_fail++;
                    $display("FAIL misaligned_rdata: got %h expected 0000", d_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (c == 1) d_req = 1'b0;
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        preload(15'h0018, 16'h5555);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'hDEAD;
        @(posedge clk);
        #1;
        rst = 1'b1;
        d_req = 1'b0; d_wr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_enable || mem_wr || d_ack || i_ack) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wait_activity: got access/ack after reset=%b expected 0", seen);
        end
        n_checks++;
        if (mem[15'h0018] !== 16'h5555) begin
            n_fail++;
            $display("FAIL reset_in_wait_word: got %h expected 5555", mem[15'h0018]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_resp();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (d_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_before_reset: got d_ack=%b expected 1", d_ack);
        end
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        n_checks++;
        if ({d_ack, d_rdata} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_in_resp: got d_ack=%b d_rdata=%h expected 0 0000", d_ack, d_rdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_latency1();
        i_req1 = 1'b1; i_addr1 = 16'h0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_enable1, i_ack1} !== {c == 1, c == 2}) begin
                n_fail++;
                $display("FAIL lat1_timing c=%0d: got en/i_ack=%b%b expected %b%b",
                         c, mem_enable1, i_ack1, c == 1, c == 2);
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr1 !== 16'h0010) begin
                    n_fail++;
                    $display("FAIL lat1_addr: got %h expected 0010", mem_addr1);
                end
            end
            if (c == 2) begin
                n_checks++;
                if ({i_err1, i_rdata1} !== {1'b0, 16'hBEEF}) begin
                    n_fail++;
                    $display("FAIL lat1_data: got err=%b rdata=%h expected err=0 rdata=beef", i_err1, i_rdata1);
                end
            end
            @(posedge clk);
            #1;
            if (c == 2) i_req1 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic        got_port [4];
        int          got_cyc  [4];
        logic [15:0] got_data [4];
        logic        exp_port [4];
        int          n_got;
        logic        both;
        do_reset();
        preload(15'h0020, 16'hD0D0);
        preload(15'h0028, 16'h1F1F);
`ifdef MEM_ARB_RR_EN
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        n_got = 0;
        both  = 1'b0;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        i_req = 1'b1; i_addr = 16'h0050;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_ack && i_ack) both = 1'b1;
            if ((d_ack || i_ack) && n_got < 4) begin
                got_port[n_got] = i_ack;
                got_cyc[n_got]  = c;
                got_data[n_got] = i_ack ? i_rdata : d_rdata;
                n_got++;
            end
            @(posedge clk);
            #1;
        end
        d_req = 1'b0; i_req = 1'b0;
        n_checks++;
        if (n_got !== 4 || both !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d acks (both=%b) expected 4 (both=0)", n_got, both);
        end
        for (int k = 0; k < n_got; k++) begin
            n_checks++;
            if ({got_port[k], got_cyc[k], got_data[k]} !==
                {exp_port[k], 4 * k + 3, exp_port[k] ? 16'h1F1F : 16'hD0D0}) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: got port=%0d cycle=%0d data=%h expected port=%0d cycle=%0d data=%h",
                         k, got_port[k], got_cyc[k], got_data[k], exp_port[k], 4 * k + 3,
                         exp_port[k] ? 16'h1F1F : 16'hD0D0);
            end
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        i_req = 1'b0; i_addr = '0;
        d_req1 = 1'b0; d_wr1 = 1'b0; d_addr1 = '0; d_wdata1 = '0;
        i_req1 = 1'b0; i_addr1 = '0;
        test_reset();
        test_data_read();
        test_write_fetch();
        test_misaligned();
        test_reset_in_wait();
        test_reset_in_resp();
        test_latency1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
